// File: rtl/network_output_queue.sv
// -----------------------------------------------------------------------------
// network_output_queue
//   Reader end of the network queue FIFO. Pops one {tsntag, bufid} descriptor
//   at a time and hands it to the transmit scheduler over a level wr/ack
//   handshake. wr is held until ack is sampled, and ack has to drop again
//   before the next descriptor is popped. Keeps a wrapping delivery count.
//
//   State table
//     IDLE_S        | waiting for a non-empty FIFO, open gate and ack low
//     WAIT_S        | pop issued, counting FIFO read latency
//     SEND_S        | descriptor presented, o_descriptor_wr held until ack
//     ACK_RELEASE_S | descriptor accepted, waiting for ack to drop
//
// Ports
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   iv_fifo_rdata      FIFO read data {tsntag, bufid}
//   i_fifo_empty       FIFO empty flag
//   o_fifo_rd          one-cycle read strobe per descriptor
//   i_gate_open        scheduler permits dequeue
//   ov_tsntag/ov_bufid descriptor fields, valid while o_descriptor_wr=1
//   o_descriptor_wr    descriptor valid, held until ack
//   i_descriptor_ack   scheduler acceptance (level)
//   ov_tx_cnt          delivered-descriptor count, wraps
//   o_protocol_err     one-cycle pulse when ack is seen while idle
// -----------------------------------------------------------------------------
module network_output_queue #(
    parameter int TAG_W           = 48,
    parameter int BUFID_W         = 9,
    parameter int FIFO_RD_LATENCY = 1,
    parameter int CNT_W           = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [TAG_W+BUFID_W-1:0] iv_fifo_rdata,
    input  logic                     i_fifo_empty,
    output logic                     o_fifo_rd,
    input  logic                     i_gate_open,
    output logic [TAG_W-1:0]         ov_tsntag,
    output logic [BUFID_W-1:0]       ov_bufid,
    output logic                     o_descriptor_wr,
    input  logic                     i_descriptor_ack,
    output logic [CNT_W-1:0]         ov_tx_cnt,
    output logic                     o_protocol_err
);

    typedef enum logic [1:0] {
        IDLE_S        = 2'd0,
        WAIT_S        = 2'd1,
        SEND_S        = 2'd2,
        ACK_RELEASE_S = 2'd3
    } state_t;

    // Latency is 1..3, so a 2-bit counter covers the whole wait.
    localparam logic [1:0] LAT_LAST = 2'(FIFO_RD_LATENCY - 1);

    state_t     state;
    logic [1:0] lat_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE_S;
            lat_cnt         <= '0;
            o_fifo_rd       <= 1'b0;
            ov_tsntag       <= '0;
            ov_bufid        <= '0;
            o_descriptor_wr <= 1'b0;
            ov_tx_cnt       <= '0;
            o_protocol_err  <= 1'b0;
        end else begin
            // Both strobes are single-cycle pulses unless re-armed below.
            o_fifo_rd      <= 1'b0;
            o_protocol_err <= 1'b0;

            case (state)
                IDLE_S: begin
                    if (i_descriptor_ack) begin
                        o_protocol_err <= 1'b1;
                    end else if (!i_fifo_empty && i_gate_open) begin
                        o_fifo_rd <= 1'b1;
                        lat_cnt   <= '0;
                        state     <= WAIT_S;
                    end
                end

                // Empty and gate are deliberately ignored: an issued pop
                // always completes so the popped entry is never lost.
                WAIT_S: begin
                    lat_cnt <= lat_cnt + 2'd1;
                    if (lat_cnt == LAT_LAST) begin
                        ov_tsntag       <= iv_fifo_rdata[TAG_W+BUFID_W-1:BUFID_W];
                        ov_bufid        <= iv_fifo_rdata[BUFID_W-1:0];
                        o_descriptor_wr <= 1'b1;
                        state           <= SEND_S;
                    end
                end

                // A gate close here does not withdraw the descriptor.
                SEND_S: begin
                    if (i_descriptor_ack) begin
                        o_descriptor_wr <= 1'b0;
                        ov_tsntag       <= '0;
                        ov_bufid        <= '0;
                        ov_tx_cnt       <= ov_tx_cnt + CNT_W'(1);
                        state           <= ACK_RELEASE_S;
                    end
                end

                ACK_RELEASE_S: begin
                    if (!i_descriptor_ack) begin
                        state <= IDLE_S;
                    end
                end

                default: begin
                    o_fifo_rd       <= 1'b0;
                    ov_tsntag       <= '0;
                    ov_bufid        <= '0;
                    o_descriptor_wr <= 1'b0;
                    ov_tx_cnt       <= '0;
                    o_protocol_err  <= 1'b0;
                    state           <= IDLE_S;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_network_output_queue.sv
module tb_network_output_queue;

    localparam int DW = 57;

    logic          clk;
    logic          rst_n;

    // main instance: latency 1, 16-bit count
    logic [DW-1:0] rdata;
    logic          empty;
    logic          rd;
    logic          gate;
    logic [47:0]   tag;
    logic [8:0]    bufid;
    logic          wr;
    logic          ack;
    logic [15:0]   cnt;
    logic          err;

    // second instance: latency 3, 4-bit count (reaches wrap quickly)
    logic [DW-1:0] d3_rdata;
    logic          d3_empty;
    logic          d3_rd;
    logic          d3_gate;
    logic [47:0]   d3_tag;
    logic [8:0]    d3_bufid;
    logic          d3_wr;
    logic          d3_ack;
    logic [3:0]    d3_cnt;
    logic          d3_err;

    int n_checks = 0;
    int n_fail   = 0;

    network_output_queue u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .iv_fifo_rdata(rdata), .i_fifo_empty(empty), .o_fifo_rd(rd),
        .i_gate_open(gate), .ov_tsntag(tag), .ov_bufid(bufid),
        .o_descriptor_wr(wr), .i_descriptor_ack(ack),
        .ov_tx_cnt(cnt), .o_protocol_err(err)
    );

    network_output_queue #(.FIFO_RD_LATENCY(3), .CNT_W(4)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .iv_fifo_rdata(d3_rdata), .i_fifo_empty(d3_empty), .o_fifo_rd(d3_rd),
        .i_gate_open(d3_gate), .ov_tsntag(d3_tag), .ov_bufid(d3_bufid),
        .o_descriptor_wr(d3_wr), .i_descriptor_ack(d3_ack),
        .ov_tx_cnt(d3_cnt), .o_protocol_err(d3_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FIFO model for the main instance ----------------
    logic [DW-1:0] mem [0:63];
    int            n_pushed = 0;
    int            h = 0;         // next entry to pop
    logic          pend;          // popped entry still being read out

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else if (rd) begin
            h    <= h + 1;
            pend <= 1'b1;
        end else if (wr) begin
            pend <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (pend && h > 0)        rdata = mem[h-1];
        else if (h < n_pushed)    rdata = mem[h];
    end
    assign empty = (h >= n_pushed);

    // ---------------- monitor: pop strobes and accepted descriptors ----
    int            rd_pulses = 0;
    logic [DW-1:0] rx [0:63];
    int            rx_n = 0;

    always @(posedge clk) begin
        if (rd) rd_pulses = rd_pulses + 1;
        if (wr && ack && rx_n < 64) begin
            rx[rx_n] = {tag, bufid};
            rx_n     = rx_n + 1;
        end
    end

    // ---------------- reference: expected delivery order and count ----
    logic [DW-1:0] exp_q [0:63];
    int            exp_n = 0;
    logic [15:0]   exp_cnt = '0;

    // ---------------- latency-3 FIFO model: data valid only in the
    // ---------------- cycle L-1 after the read strobe cycle ------------
    logic [DW-1:0] d3_val;
    logic [1:0]    d3_age;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            d3_age <= 2'd0;
        else if (d3_rd)        d3_age <= 2'd1;
        else if (d3_age != 0)  d3_age <= d3_age + 2'd1;
    end
    assign d3_rdata = (d3_age == 2'd2) ? d3_val : ~d3_val;

    task automatic push(input logic [DW-1:0] d);
        mem[n_pushed] = d;
        n_pushed++;
    endtask

    // Waits for wr, checks the presented descriptor, acks after 'delay' cycles.
    task automatic deliver(input logic [DW-1:0] exp, input int delay);
        int t = 0;
        while (wr !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (wr !== 1'b1) begin
            n_fail++;
            $display("FAIL deliver_timeout wr=%b expected 1", wr);
            return;
        end
        n_checks++;
        if ({tag, bufid} !== exp) begin
            n_fail++;
            $display("FAIL deliver_data got %h expected %h", {tag, bufid}, exp);
        end
        repeat (delay) @(negedge clk);
        n_checks++;
        if (wr !== 1'b1 || {tag, bufid} !== exp) begin
            n_fail++;
            $display("FAIL deliver_hold wr=%b data=%h expected 1/%h", wr, {tag, bufid}, exp);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        exp_q[exp_n] = exp;
        exp_n++;
        n_checks++;
        if (wr !== 1'b0 || cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL deliver_accept wr=%b cnt=%0d expected 0/%0d", wr, cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        int t = 0;
        int base;
        logic [DW-1:0] a, b;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd, wr, tag, bufid, cnt, err} !== '0 || {d3_rd, d3_wr, d3_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rd=%b wr=%b tag=%h bufid=%h cnt=%0d err=%b expected all 0",
                     rd, wr, tag, bufid, cnt, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        a = DW'({$urandom, $urandom});
        b = DW'({$urandom, $urandom});
        push(a);
        push(b);
        gate = 1'b1;
        deliver(a, 0);
        while (wr !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        // reset in the middle of a cycle while b is being presented
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rd, wr, tag, bufid, cnt, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_send got wr=%b tag=%h bufid=%h cnt=%0d expected all 0",
                     wr, tag, bufid, cnt);
        end
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        base = rd_pulses;
        repeat (5) @(negedge clk);
        n_checks++;
        if (cnt !== 16'd0 || wr !== 1'b0 || rd_pulses != base) begin
            n_fail++;
            $display("FAIL reset_release cnt=%0d wr=%b pops=%0d expected 0/0/%0d", cnt, wr, rd_pulses, base);
        end
    endtask

    task automatic test_single_pop();
        int t = 0;
        logic [DW-1:0] d = {48'h0123_4567_89AB, 9'h05A};
        push(d);
        gate = 1'b1;
        while (rd !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (rd !== 1'b1 || wr !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop_strobe rd=%b wr=%b expected 1/0", rd, wr);
        end
        @(negedge clk);
        n_checks++;
        if (rd !== 1'b0 || wr !== 1'b1 || tag !== 48'h0123_4567_89AB || bufid !== 9'h05A) begin
            n_fail++;
            $display("FAIL single_pop_present rd=%b wr=%b tag=%h bufid=%h expected 0/1/0123456789ab/05a",
                     rd, wr, tag, bufid);
        end
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (wr !== 1'b1 || {tag, bufid} !== d) begin
                n_fail++;
                $display("FAIL single_pop_hold cycle %0d wr=%b data=%h expected 1/%h", k, wr, {tag, bufid}, d);
            end
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        exp_q[exp_n] = d;
        exp_n++;
        n_checks++;
        if (wr !== 1'b0 || cnt !== 16'd1 || {tag, bufid} !== '0) begin
            n_fail++;
            $display("FAIL single_pop_accept wr=%b cnt=%0d data=%h expected 0/1/0", wr, cnt, {tag, bufid});
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d [4];
        int base = rd_pulses;
        for (int i = 0; i < 4; i++) begin
            d[i] = DW'({$urandom, $urandom});
            push(d[i]);
        end
        gate = 1'b1;
        for (int i = 0; i < 4; i++) deliver(d[i], 1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (rd_pulses - base != 4 || cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL back_to_back pops=%0d cnt=%0d expected 4/%0d", rd_pulses - base, cnt, exp_cnt);
        end
    endtask

    task automatic test_gate();
        int base = rd_pulses;
        int t = 0;
        logic [DW-1:0] d = DW'({$urandom, $urandom});
        gate = 1'b0;
        push(d);
        repeat (6) @(negedge clk);
        n_checks++;
        if (rd_pulses != base || rd !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_closed_pop pops=%0d expected %0d", rd_pulses - base, 0);
        end
        gate = 1'b1;
        while (wr !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        gate = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (wr !== 1'b1 || {tag, bufid} !== d) begin
                n_fail++;
                $display("FAIL gate_closed_send wr=%b data=%h expected 1/%h", wr, {tag, bufid}, d);
            end
        end
        deliver(d, 0);
    endtask

    task automatic test_ack_stuck();
        int t = 0;
        int base;
        logic [DW-1:0] a = DW'({$urandom, $urandom});
        logic [DW-1:0] b = DW'({$urandom, $urandom});
        push(a);
        push(b);
        gate = 1'b1;
        while (wr !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        ack = 1'b1;
        base = rd_pulses;
        repeat (4) @(negedge clk);
        n_checks++;
        if (rd_pulses != base || wr !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_stuck_no_pop pops=%0d wr=%b err=%b expected %0d/0/0", rd_pulses, wr, err, base);
        end
        ack = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        exp_q[exp_n] = a;
        exp_n++;
        @(negedge clk);
        n_checks++;
        if (rd !== 1'b0 || cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL ack_release_early rd=%b cnt=%0d expected 0/%0d", rd, cnt, exp_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (rd !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_release_pop rd=%b expected 1", rd);
        end
        deliver(b, 0);
        repeat (3) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL protocol_err_pulse err=%b expected 1", err);
        end
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL protocol_err_clear err=%b cnt=%0d expected 0/%0d", err, cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        for (int i = 0; i < 20; i++) begin
            d = DW'({$urandom, $urandom});
            gate = 1'b0;
            push(d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            gate = 1'b1;
            deliver(d, int'($urandom_range(0, 4)));
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rx_n != exp_n || rd_pulses != n_pushed || cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL scoreboard_totals rx=%0d pops=%0d cnt=%0d expected %0d/%0d/%0d",
                     rx_n, rd_pulses, cnt, exp_n, n_pushed, exp_cnt);
        end
        for (int i = 0; i < exp_n && i < rx_n; i++) begin
            n_checks++;
            if (rx[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL scoreboard_order idx %0d got %h expected %h", i, rx[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap_latency();
        int t;
        int lat;
        logic [3:0] exp3 = d3_cnt;
        d3_gate = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d3_val   = DW'({$urandom, $urandom});
            d3_empty = 1'b0;
            t = 0;
            while (d3_rd !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            d3_empty = 1'b1;
            lat = 0;
            while (d3_wr !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            n_checks++;
            if (lat != 3 || {d3_tag, d3_bufid} !== d3_val) begin
                n_fail++;
                $display("FAIL latency3 iter %0d wr after %0d cycles data=%h expected 3/%h",
                         i, lat, {d3_tag, d3_bufid}, d3_val);
            end
            d3_ack = 1'b1;
            @(negedge clk);
            d3_ack = 1'b0;
            exp3 = exp3 + 4'd1;
            @(negedge clk);
            if (i == 14 || i == 15) begin
                n_checks++;
                if (d3_cnt !== exp3) begin
                    n_fail++;
                    $display("FAIL wrap_count iter %0d cnt=%0d expected %0d", i, d3_cnt, exp3);
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        gate     = 1'b0;
        ack      = 1'b0;
        d3_empty = 1'b1;
        d3_gate  = 1'b0;
        d3_ack   = 1'b0;
        d3_val   = '0;
        test_reset();
        test_single_pop();
        test_back_to_back();
        test_gate();
        test_ack_stuck();
        test_random();
        test_wrap_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
